serial_subtractor_ctrl: RTL and testbench

//  Bit-serial N-bit subtract sequencer built around one full_subtractor_c cell.

---
 rtl/serial_sub_pkg.sv | 26 ++
 rtl/full_subtractor_c.sv | 22 ++
 rtl/serial_subtractor_ctrl.sv | 136 +++++++++++++
 tb/tb_serial_subtractor_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// ---------------------------------------------------------------------------
// serial_sub_pkg
//   Shared definitions for the bit-serial subtract sequencer: the FSM state
//   encoding, the widest supported operand width and the helper that sizes
//   the bit counter.
// ---------------------------------------------------------------------------
package serial_sub_pkg;

    localparam int MAX_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // A 1-bit operand still needs a 1-bit counter (its only value is 0).
    function automatic int cnt_width(input int w);
        if (w > 1) begin
            return $clog2(w);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/full_subtractor_c.sv
// ---------------------------------------------------------------------------
// full_subtractor_c
//   One-bit full subtractor: a - b - bin.
//   Ports:
//     a, b  in   operand bits (minuend, subtrahend)
//     bin   in   borrow in
//     diff  out  difference bit
//     bout  out  borrow out
// ---------------------------------------------------------------------------
module full_subtractor_c (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    // Borrow when b exceeds a, or when they are equal and a borrow arrives.
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// ---------------------------------------------------------------------------
// serial_subtractor_ctrl
//   Bit-serial WIDTH-bit subtractor. Operands and borrow-in are captured on
//   an accepted start, fed LSB-first through one full_subtractor_c for WIDTH
//   cycles with the borrow carried in a flop, then the result is published
//   together with a one-cycle done pulse.
//   Ports:
//     clk    in   clock, all state on posedge
//     rst    in   synchronous active-high reset (aborts any operation)
//     start  in   request, accepted only while busy is low
//     a, b   in   minuend / subtrahend, sampled in the accepting cycle
//     bin    in   initial borrow, sampled in the accepting cycle
//     busy   out  high in RUN and DONE
//     done   out  one-cycle pulse when diff/bout are newly updated
//     diff   out  registered difference, held until next completion
//     bout   out  registered final borrow, held until next completion
// ---------------------------------------------------------------------------
module serial_subtractor_ctrl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t           state_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] a_sr_r;
    logic [WIDTH-1:0] b_sr_r;
    logic [WIDTH-1:0] r_sr_r;
    logic             brw_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] diff_r;
    logic             bout_r;

    logic             cell_diff_s;
    logic             cell_bout_s;
    logic [WIDTH-1:0] r_next_s;

    full_subtractor_c u_cell (
        .a    (a_sr_r[0]),
        .b    (b_sr_r[0]),
        .bin  (brw_r),
        .diff (cell_diff_s),
        .bout (cell_bout_s)
    );

    // Result shift register input: the new bit enters at the MSB so that
    // after WIDTH shifts the LSB computed first sits at bit 0.
    generate
        if (WIDTH == 1) begin : g_r_one
            assign r_next_s = cell_diff_s;
        end else begin : g_r_multi
            assign r_next_s = {cell_diff_s, r_sr_r[WIDTH-1:1]};
        end
    endgenerate

    // Sequencer FSM with datapath shift registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            a_sr_r  <= '0;
            b_sr_r  <= '0;
            r_sr_r  <= '0;
            brw_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            diff_r  <= '0;
            bout_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        a_sr_r  <= a;
                        b_sr_r  <= b;
                        brw_r   <= bin;
                        r_sr_r  <= '0;
                        cnt_r   <= '0;
                        busy_r  <= 1'b1;
                        state_r <= ST_RUN;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_sr_r <= r_next_s;
                    brw_r  <= cell_bout_s;
                    a_sr_r <= a_sr_r >> 1;
                    b_sr_r <= b_sr_r >> 1;
                    if (cnt_r == CNT_LAST) begin
                        diff_r  <= r_next_s;
                        bout_r  <= cell_bout_s;
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        cnt_r   <= cnt_r + CNT_ONE;
                        state_r <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign diff = diff_r;
    assign bout = bout_r;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor_ctrl
//   Self-checking bench: one WIDTH=8 instance for directed, table-driven and
//   random operations, plus WIDTH=3 and WIDTH=1 instances swept exhaustively.
//   Expected results come from plain integer arithmetic on the operands.
// ---------------------------------------------------------------------------
module tb_serial_subtractor_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // WIDTH=8 instance
    logic       st8 = 1'b0, bin8 = 1'b0;
    logic [7:0] a8 = 8'd0, b8 = 8'd0;
    logic       busy8, done8, bout8;
    logic [7:0] diff8;

    // WIDTH=3 instance
    logic       st3 = 1'b0, bin3 = 1'b0;
    logic [2:0] a3 = 3'd0, b3 = 3'd0;
    logic       busy3, done3, bout3;
    logic [2:0] diff3;

    // WIDTH=1 instance
    logic       st1 = 1'b0, bin1 = 1'b0;
    logic [0:0] a1 = 1'b0, b1 = 1'b0;
    logic       busy1, done1, bout1;
    logic [0:0] diff1;

    serial_subtractor_ctrl #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(st8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8));

    serial_subtractor_ctrl #(.WIDTH(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(st3), .a(a3), .b(b3), .bin(bin3),
        .busy(busy3), .done(done3), .diff(diff3), .bout(bout3));

    serial_subtractor_ctrl #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(st1), .a(a1), .b(b1), .bin(bin1),
        .busy(busy1), .done(done1), .diff(diff1), .bout(bout1));

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] exp_diff;
        logic       exp_bout;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: (a - b - bin) mod 2^w, borrow iff a < b + bin.
    function automatic logic [8:0] model(input int w, input int a, input int b, input int bin);
        int raw;
        int mask;
        logic [8:0] res;
        mask = (1 << w) - 1;
        raw  = a - b - bin;
        res[7:0] = 8'(raw & mask);
        res[8]   = (a < b + bin) ? 1'b1 : 1'b0;
        return res;
    endfunction

    task automatic drive(input int idx, input logic s, input logic [7:0] a, input logic [7:0] b,
                         input logic bi);
        case (idx)
            0: begin st8 = s; a8 = a;      b8 = b;      bin8 = bi; end
            1: begin st3 = s; a3 = a[2:0]; b3 = b[2:0]; bin3 = bi; end
            default: begin st1 = s; a1 = a[0:0]; b1 = b[0:0]; bin1 = bi; end
        endcase
    endtask

    function automatic logic [11:0] sample(input int idx);
        // {busy, done, bout, diff[7:0]} zero-extended
        case (idx)
            0:       return {1'b0, busy8, done8, bout8, diff8};
            1:       return {1'b0, busy3, done3, bout3, 5'd0, diff3};
            default: return {1'b0, busy1, done1, bout1, 7'd0, diff1};
        endcase
    endfunction

    // Issue one op on a cycle where busy is low; returns result and latency
    // (negedges after the accepting edge until done is seen). mode 1 pulses
    // a spurious start during RUN.
    task automatic run_op(input int idx, input logic [7:0] a, input logic [7:0] b,
                          input logic bi, input int mode, output logic [7:0] d,
                          output logic bo, output int lat, output logic hold_bad);
        logic [11:0] s;
        logic [7:0]  d_before;
        @(negedge clk);
        s = sample(idx);
        chk("idle_before_issue", {31'd0, s[10]}, 32'd0);
        d_before = s[7:0];
        drive(idx, 1'b1, a, b, bi);
        lat = -1;
        hold_bad = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) drive(idx, 1'b0, a, b, bi);
            if (mode == 1 && k == 3) drive(idx, 1'b1, 8'hFF, 8'h01, 1'b0);
            if (mode == 1 && k == 4) drive(idx, 1'b0, 8'hFF, 8'h01, 1'b0);
            s = sample(idx);
            if (s[9]) begin
                lat = k;
                break;
            end
            if (s[7:0] !== d_before) hold_bad = 1'b1;
        end
        if (lat < 0) chk("done_timeout", 32'd0, 32'd1);
        d  = s[7:0];
        bo = s[8];
    endtask

    initial begin
        logic [7:0]  d;
        logic        bo, hb;
        int          lat;
        int          cnt;
        logic [8:0]  m;
        logic [7:0]  ra, rb;
        logic        rbi;

        vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1};
        vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[4] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0};
        vecs[5] = '{8'h00, 8'hFF, 1'b0, 8'h01, 1'b1};

        // Reset for two cycles and check reset values
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", {31'd0, busy8}, 32'd0);
        chk("rst_done", {31'd0, done8}, 32'd0);
        chk("rst_diff", {24'd0, diff8}, 32'd0);
        chk("rst_bout", {31'd0, bout8}, 32'd0);

        // Table-driven vectors (entry 0 is the basic latency case)
        for (int i = 0; i < 6; i++) begin
            run_op(0, vecs[i].a, vecs[i].b, vecs[i].bin, 0, d, bo, lat, hb);
            chk("vec_diff", {24'd0, d}, {24'd0, vecs[i].exp_diff});
            chk("vec_bout", {31'd0, bo}, {31'd0, vecs[i].exp_bout});
            chk("vec_latency", lat, 32'd9);
            chk("vec_hold_in_run", {31'd0, hb}, 32'd0);
        end

        // Starts during RUN and DONE are ignored
        run_op(0, 8'hA0, 8'h10, 1'b0, 1, d, bo, lat, hb);
        chk("busy_at_done", {31'd0, busy8}, 32'd1);
        chk("ignore_diff", {24'd0, d}, 32'h90);
        chk("ignore_bout", {31'd0, bo}, 32'd0);
        chk("ignore_latency", lat, 32'd9);
        drive(0, 1'b1, 8'hFF, 8'h01, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, 8'hFF, 8'h01, 1'b0);
        chk("ignore_busy_after_done", {31'd0, busy8}, 32'd0);
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8 || busy8) cnt++;
        end
        chk("ignore_no_extra_op", cnt, 32'd0);

        // Reset mid-RUN aborts with no done
        @(negedge clk);
        drive(0, 1'b1, 8'h80, 8'h01, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) drive(0, 1'b0, 8'h80, 8'h01, 1'b0);
        end
        chk("abort_busy_before", {31'd0, busy8}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", {31'd0, busy8}, 32'd0);
        chk("abort_diff", {24'd0, diff8}, 32'd0);
        chk("abort_bout", {31'd0, bout8}, 32'd0);
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) cnt++;
        end
        chk("abort_no_done", cnt, 32'd0);
        run_op(0, 8'h80, 8'h01, 1'b0, 0, d, bo, lat, hb);
        chk("after_abort_diff", {24'd0, d}, 32'h7F);
        chk("after_abort_bout", {31'd0, bo}, 32'd0);

        // rst and start together: request dropped
        @(negedge clk);
        rst = 1'b1;
        drive(0, 1'b1, 8'h33, 8'h11, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 1'b0, 8'h33, 8'h11, 1'b0);
        chk("rst_start_busy", {31'd0, busy8}, 32'd0);
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8 || busy8) cnt++;
        end
        chk("rst_start_no_done", cnt, 32'd0);

        // Random operations against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            ra  = 8'($urandom_range(0, 255));
            rb  = 8'($urandom_range(0, 255));
            rbi = 1'($urandom_range(0, 1));
            m   = model(8, int'(ra), int'(rb), int'(rbi));
            run_op(0, ra, rb, rbi, 0, d, bo, lat, hb);
            chk("rand_diff", {24'd0, d}, {24'd0, m[7:0]});
            chk("rand_bout", {31'd0, bo}, {31'd0, m[8]});
            chk("rand_latency", lat, 32'd9);
        end

        // Exhaustive WIDTH=3, issued back to back (spacing = latency + 1)
        for (int ia = 0; ia < 8; ia++) begin
            for (int ib = 0; ib < 8; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    m = model(3, ia, ib, ic);
                    run_op(1, 8'(ia), 8'(ib), 1'(ic), 0, d, bo, lat, hb);
                    chk("w3_diff", {24'd0, d}, {24'd0, m[7:0]});
                    chk("w3_bout", {31'd0, bo}, {31'd0, m[8]});
                    chk("w3_latency", lat, 32'd4);
                end
            end
        end

        // Exhaustive WIDTH=1
        for (int ia = 0; ia < 2; ia++) begin
            for (int ib = 0; ib < 2; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    m = model(1, ia, ib, ic);
                    run_op(2, 8'(ia), 8'(ib), 1'(ic), 0, d, bo, lat, hb);
                    chk("w1_diff", {24'd0, d}, {24'd0, m[7:0]});
                    chk("w1_bout", {31'd0, bo}, {31'd0, m[8]});
                    chk("w1_latency", lat, 32'd2);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
